// File: rtl/cmd_ctrl_rx.sv
// Receive-side command controller: parses UART RX byte frames and launches
// register-file writes/reads and ALU operations, with a bounded result wait.
module cmd_ctrl_rx #(
  parameter int BusWidth      = 8,
  parameter int AddrWidth     = 4,
  parameter int FuncWidth     = 4,
  parameter int TimeoutCycles = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BusWidth-1:0]  RX_P_Data,
  input  logic                 RX_D_VLD,
  input  logic                 RdData_Valid,
  input  logic                 ALU_OUT_VLD,
  output logic [AddrWidth-1:0] Address,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [BusWidth-1:0]  WrData,
  output logic                 ALU_EN,
  output logic [FuncWidth-1:0] ALU_FUN,
  output logic                 CLK_EN,
  output logic                 Busy,
  output logic                 CMD_ERR
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    ALU_A    = 4'd5,
    ALU_B    = 4'd6,
    ALU_FN   = 4'd7,
    ALU_WAIT = 4'd8
  } state_t;

  localparam logic [BusWidth-1:0] CMD_WR     = BusWidth'(8'hAA);
  localparam logic [BusWidth-1:0] CMD_RD     = BusWidth'(8'hBB);
  localparam logic [BusWidth-1:0] CMD_ALU_OP = BusWidth'(8'hCC);
  localparam logic [BusWidth-1:0] CMD_ALU_NO = BusWidth'(8'hDD);
  localparam logic [7:0]          TO_LIMIT   = 8'(TimeoutCycles);

  state_t               state_r, state_nxt_s;
  logic [AddrWidth-1:0] addr_r, addr_nxt_s;
  logic [FuncWidth-1:0] func_r, func_nxt_s;
  logic [7:0]           cnt_r, cnt_nxt_s;
  logic                 err_r, err_s;
  logic                 wren_s, rden_s, alu_en_s, clk_en_s;
  logic [AddrWidth-1:0] address_s;
  logic [BusWidth-1:0]  wrdata_s;

  // Next-state, register updates and Mealy strobes for the command parser
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    func_nxt_s  = func_r;
    cnt_nxt_s   = cnt_r;
    err_s       = 1'b0;
    wren_s      = 1'b0;
    rden_s      = 1'b0;
    alu_en_s    = 1'b0;
    clk_en_s    = 1'b0;
    address_s   = addr_r;
    wrdata_s    = {BusWidth{1'b0}};
    case (state_r)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_Data)
            CMD_WR:     state_nxt_s = WR_ADDR;
            CMD_RD:     state_nxt_s = RD_ADDR;
            CMD_ALU_OP: state_nxt_s = ALU_A;
            CMD_ALU_NO: state_nxt_s = ALU_FN;
            default:    err_s       = 1'b1;
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nxt_s  = RX_P_Data[AddrWidth-1:0];
          state_nxt_s = WR_DATA;
        end else begin
          state_nxt_s = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wren_s      = 1'b1;
          wrdata_s    = RX_P_Data;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_DATA;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rden_s      = 1'b1;
          address_s   = RX_P_Data[AddrWidth-1:0];
          cnt_nxt_s   = 8'd0;
          state_nxt_s = RD_WAIT;
        end else begin
          state_nxt_s = RD_ADDR;
        end
      end
      RD_WAIT: begin
        // A valid on the limit cycle still completes the read cleanly
        if (RdData_Valid) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == TO_LIMIT) begin
          err_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      ALU_A: begin
        if (RX_D_VLD) begin
          wren_s      = 1'b1;
          address_s   = {AddrWidth{1'b0}};
          wrdata_s    = RX_P_Data;
          state_nxt_s = ALU_B;
        end else begin
          state_nxt_s = ALU_A;
        end
      end
      ALU_B: begin
        if (RX_D_VLD) begin
          wren_s      = 1'b1;
          address_s   = AddrWidth'(1'b1);
          wrdata_s    = RX_P_Data;
          state_nxt_s = ALU_FN;
        end else begin
          state_nxt_s = ALU_B;
        end
      end
      ALU_FN: begin
        clk_en_s = 1'b1;
        if (RX_D_VLD) begin
          func_nxt_s  = RX_P_Data[FuncWidth-1:0];
          cnt_nxt_s   = 8'd0;
          state_nxt_s = ALU_WAIT;
        end else begin
          state_nxt_s = ALU_FN;
        end
      end
      ALU_WAIT: begin
        clk_en_s = 1'b1;
        alu_en_s = 1'b1;
        if (ALU_OUT_VLD) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == TO_LIMIT) begin
          err_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, captured address/function, wait counter and error pulse registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      addr_r  <= {AddrWidth{1'b0}};
      func_r  <= {FuncWidth{1'b0}};
      cnt_r   <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      addr_r  <= addr_nxt_s;
      func_r  <= func_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_s;
    end
  end

  assign Address = address_s;
  assign WrEn    = wren_s;
  assign RdEn    = rden_s;
  assign WrData  = wrdata_s;
  assign ALU_EN  = alu_en_s;
  assign ALU_FUN = func_r;
  assign CLK_EN  = clk_en_s;
  assign Busy    = (state_r != IDLE);
  assign CMD_ERR = err_r;

endmodule

// File: tb/tb_cmd_ctrl_rx.sv
// Randomized bench for cmd_ctrl_rx: expected outputs come from the command
// transactions the bench itself issues, checked every cycle before the edge.
module tb_cmd_ctrl_rx;

  localparam int TO = 255;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_Data;
  logic       RX_D_VLD, RdData_Valid, ALU_OUT_VLD;
  logic [3:0] Address;
  logic       WrEn, RdEn;
  logic [7:0] WrData;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_EN, Busy, CMD_ERR;

  cmd_ctrl_rx dut (
    .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .RdData_Valid(RdData_Valid), .ALU_OUT_VLD(ALU_OUT_VLD),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .Busy(Busy),
    .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: last written address, last ALU function, pending error
  logic [3:0] m_addr = 4'd0;
  logic [3:0] m_func = 4'd0;
  logic       err_pend = 1'b0;
  logic       e_busy, e_wren, e_rden, e_aluen, e_clken;
  logic [3:0] e_addr;
  logic [7:0] e_wdata;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (Busy,ERR,WrEn,RdEn,ALU_EN,CLK_EN,Addr,WrData,FUN)",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {10'd0, Busy, CMD_ERR, WrEn, RdEn, ALU_EN, CLK_EN, Address, WrData, ALU_FUN};
  endfunction

  task automatic quiet(input logic busy, input logic aluen, input logic clken);
    e_busy = busy; e_wren = 1'b0; e_rden = 1'b0; e_addr = m_addr;
    e_wdata = 8'd0; e_aluen = aluen; e_clken = clken;
  endtask

  task automatic tick(input logic vld, input logic [7:0] d, input logic rdv,
                      input logic aluv, input string tag);
    @(negedge CLK);
    RX_D_VLD = vld; RX_P_Data = d; RdData_Valid = rdv; ALU_OUT_VLD = aluv;
    #1;
    chk_eq(tag, outs(), {10'd0, e_busy, err_pend, e_wren, e_rden, e_aluen, e_clken,
                         e_addr, e_wdata, m_func});
    err_pend = 1'b0;
  endtask

  function automatic int pick(input int g);
    return (g < 0) ? int'($urandom_range(0, 3)) : g;
  endfunction

  task automatic gaps(input int n, input logic busy, input logic aluen, input logic clken);
    for (int i = 0; i < n; i++) begin
      quiet(busy, aluen, clken);
      tick(1'b0, 8'($urandom), 1'b0, 1'b0, "gap");
    end
  endtask

  // Result wait: valid arrives on wait cycle `lat`; no valid by cycle TO aborts
  task automatic wait_phase(input logic is_alu, input int lat);
    for (int k = 0; k <= TO; k++) begin
      quiet(1'b1, is_alu, is_alu);
      tick($urandom_range(0, 3) == 0, 8'($urandom), !is_alu && (k == lat),
           is_alu && (k == lat), is_alu ? "alu_wait" : "rd_wait");
      if (k == lat) break;
      if (k == TO) err_pend = 1'b1;
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int g);
    quiet(1'b0, 1'b0, 1'b0); tick(1'b1, 8'hAA, 1'b0, 1'b0, "wr_cmd");
    gaps(pick(g), 1'b1, 1'b0, 1'b0);
    quiet(1'b1, 1'b0, 1'b0); tick(1'b1, a, 1'b0, 1'b0, "wr_addr");
    m_addr = a[3:0];
    gaps(pick(g), 1'b1, 1'b0, 1'b0);
    quiet(1'b1, 1'b0, 1'b0); e_wren = 1'b1; e_wdata = d;
    tick(1'b1, d, 1'b0, 1'b0, "wr_data");
  endtask

  task automatic do_read(input logic [7:0] a, input int lat, input int g);
    quiet(1'b0, 1'b0, 1'b0); tick(1'b1, 8'hBB, 1'b0, 1'b0, "rd_cmd");
    gaps(pick(g), 1'b1, 1'b0, 1'b0);
    quiet(1'b1, 1'b0, 1'b0); e_rden = 1'b1; e_addr = a[3:0];
    tick(1'b1, a, 1'b0, 1'b0, "rd_addr");
    wait_phase(1'b0, lat);
  endtask

  task automatic do_alu(input logic ops, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] f, input int lat, input int g);
    quiet(1'b0, 1'b0, 1'b0);
    tick(1'b1, ops ? 8'hCC : 8'hDD, 1'b0, 1'b0, "alu_cmd");
    if (ops) begin
      gaps(pick(g), 1'b1, 1'b0, 1'b0);
      quiet(1'b1, 1'b0, 1'b0); e_wren = 1'b1; e_addr = 4'd0; e_wdata = x;
      tick(1'b1, x, 1'b0, 1'b0, "alu_opa");
      gaps(pick(g), 1'b1, 1'b0, 1'b0);
      quiet(1'b1, 1'b0, 1'b0); e_wren = 1'b1; e_addr = 4'd1; e_wdata = y;
      tick(1'b1, y, 1'b0, 1'b0, "alu_opb");
    end
    gaps(pick(g), 1'b1, 1'b0, 1'b1);
    quiet(1'b1, 1'b0, 1'b1); tick(1'b1, f, 1'b0, 1'b0, "alu_fn");
    m_func = f[3:0];
    wait_phase(1'b1, lat);
  endtask

  task automatic do_bad(input logic [7:0] b);
    quiet(1'b0, 1'b0, 1'b0); tick(1'b1, b, 1'b0, 1'b0, "bad_cmd");
    err_pend = 1'b1;
  endtask

  initial begin
    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_Data = 8'd0;
    RdData_Valid = 1'b0; ALU_OUT_VLD = 1'b0;
    #3;
    chk_eq("reset", outs(), 32'd0);
    @(negedge CLK); RST = 1'b1;

    do_write(8'h05, 8'h3C, 2);
    gaps(1, 1'b0, 1'b0, 1'b0);
    do_read(8'h07, 4, 0);
    gaps(1, 1'b0, 1'b0, 1'b0);
    do_alu(1'b1, 8'h12, 8'h34, 8'h01, 3, 0);
    do_alu(1'b0, 8'h00, 8'h00, 8'h02, 2, 1);
    do_write(8'h00, 8'h00, 0);
    do_bad(8'h55);
    gaps(2, 1'b0, 1'b0, 1'b0);
    do_read(8'hF3, 1000, 0);
    gaps(2, 1'b0, 1'b0, 1'b0);
    do_read(8'h02, TO, 0);
    gaps(2, 1'b0, 1'b0, 1'b0);
    do_alu(1'b0, 8'h00, 8'h00, 8'hA6, 1000, 0);
    gaps(1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an ALU wait
    quiet(1'b0, 1'b0, 1'b0); tick(1'b1, 8'hDD, 1'b0, 1'b0, "rst_alu_cmd");
    quiet(1'b1, 1'b0, 1'b1); tick(1'b1, 8'h03, 1'b0, 1'b0, "rst_alu_fn");
    m_func = 4'd3;
    gaps(3, 1'b1, 1'b1, 1'b1);
    @(negedge CLK); #2 RST = 1'b0;
    #1 chk_eq("rst_mid", outs(), 32'd0);
    m_addr = 4'd0; m_func = 4'd0; err_pend = 1'b0;
    RX_D_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
    @(negedge CLK); RST = 1'b1;
    do_read(8'h01, 2, 0);

    for (int t = 0; t < 60; t++) begin
      int kind, lat;
      logic [7:0] b;
      kind = int'($urandom_range(0, 4));
      lat  = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? TO : 400)
                                         : int'($urandom_range(0, 12));
      gaps(int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
      case (kind)
        0: do_write(8'($urandom), 8'($urandom), -1);
        1: do_read(8'($urandom), lat, -1);
        2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), lat, -1);
        3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), lat, -1);
        default: begin
          b = 8'($urandom);
          if (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) b = b ^ 8'h01;
          do_bad(b);
        end
      endcase
    end
    gaps(2, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
